dice_game_ctrl: RTL
===================

Name: dice_game_ctrl

Overview:
- Two-player round sequencer for the dice-throwing datapath. It drives the roll strobes of the two random-number generators and paces them into fixed-length "tumble" bursts.
- After each burst it latches each player's final dice value, compares the two values and keeps the match score.
- It sits between the debounced start buttons and the two random generators, and feeds the display/LED logic.

Parameters:
- TICK_DIV, 100, clk cycles between successive roll strobes (1 kHz clk -> 0.1 s).
- ROLL_TICKS, 10, roll strobes issued per player turn.
- RESULT_HOLD, 1000, clk cycles the round result is held before the next round.
- WIN_SCORE, 5, score that ends the match (1..9).

Ports:
- clk  input  1  system clock (1 kHz).
- rst  input  1  reset, asynchronous, active-high.
- start1  input  1  player 1 start; single-cycle pulse, synchronous, debounced upstream.
- start2  input  1  player 2 start; same format as start1.
- dice1  input  4  live value from generator 1 (0..9).
- dice2  input  4  live value from generator 2 (0..9).
- roll1  output  1  roll strobe to generator 1; single-cycle pulse.
- roll2  output  1  roll strobe to generator 2; single-cycle pulse.
- hold1  output  4  player 1 latched result.
- hold2  output  4  player 2 latched result.
- score1  output  4  player 1 match score.
- score2  output  4  player 2 match score.
- winner  output  2  round result: 00 none, 01 P1, 10 P2, 11 draw.
- game_over  output  1  high while in OVER.
- state  output  3  current FSM state encoding, for display.

Behaviour:
- Reset (rst) is asynchronous, active-high, on clock clk.
  - While rst=1: state=IDLE; roll1, roll2, hold1, hold2, score1, score2, winner, game_over and all internal counters are 0.
  - rst asserted mid-operation drops any roll strobe immediately and abandons the round.
- FSM states and encodings: IDLE=0, ROLL1=1, LATCH1=2, WAIT2=3, ROLL2=4, LATCH2=5, RESULT=6, OVER=7.
- IDLE
  - start1=1 -> ROLL1; clear winner to 00; clear tick and burst counters.
  - start2 is ignored. Simultaneous start1 and start2: start1 is taken.
- ROLL1
  - Tick counter runs 0..TICK_DIV-1. roll1=1 for exactly the cycle in which tick=TICK_DIV-1; the counter then wraps to 0.
  - The first strobe occurs TICK_DIV cycles after entry.
  - After the ROLL_TICKS-th strobe -> LATCH1 on the next edge.
  - start1 and start2 are ignored.
- LATCH1 (1 cycle): hold1 <= dice1. The generator updates on the edge that samples roll, so dice1 is valid here. -> WAIT2.
- WAIT2: start2=1 -> ROLL2; start1 is ignored.
- ROLL2: identical timing to ROLL1, driving roll2 only. roll1 stays 0.
- LATCH2 (1 cycle): hold2 <= dice2. Compare hold1 against dice2 (unsigned 4-bit) and register the result on the same edge:
  - P1 higher: winner=01, score1+1.
  - P2 higher: winner=10, score2+1.
  - Equal: winner=11, scores unchanged.
  - -> RESULT.
- RESULT
  - Counts RESULT_HOLD cycles; starts are ignored.
  - At terminal count: score1==WIN_SCORE or score2==WIN_SCORE -> OVER, otherwise -> IDLE.
- OVER
  - game_over=1; hold1, hold2, scores and winner are frozen.
  - A lone start1 or start2 is ignored.
  - start1 and start2 in the same cycle: scores, holds and winner clear to 0 -> IDLE.
- Width rules:
  - Scores never exceed WIN_SCORE, so no wrap is possible.
  - Tick counter is wide enough for TICK_DIV-1; burst counter is wide enough for ROLL_TICKS.
- roll1 and roll2 are never high in the same cycle, and never high outside ROLL1/ROLL2.
- All outputs are registered.

Test Plan:
(Sim parameters for all scenarios: TICK_DIV=4, ROLL_TICKS=3, RESULT_HOLD=5, WIN_SCORE=2; generator behavioural model.)
- Reset: assert rst for 3 cycles -> state=0 and all outputs 0. Assert rst mid-ROLL1 while roll1=1 -> roll1 falls without waiting for a clock edge; state=0.
- P1 burst: start1 pulse in IDLE -> exactly 3 roll1 pulses on cycles 4, 8 and 12 after entry; roll2 stays 0. In LATCH1, hold1 equals the dice1 value present that cycle; then state=3.
- P1 wins round: model forces final dice1=7 and dice2=3 -> after LATCH2, winner=01, score1=1, score2=0. RESULT lasts 5 cycles, then state=0.
- Draw: dice1=5, dice2=5 -> winner=11, scores unchanged. A following start1 clears winner to 00 on entry to ROLL1.
- Ignored inputs: start2 in IDLE, start1 in WAIT2, any start during ROLL1, ROLL2 or RESULT -> no state change, no extra strobes.
- Match end: P2 wins two rounds -> score2=2, state=7, game_over=1. A lone start1 -> no change. start1 and start2 together -> scores and holds 0, state=0, game_over=0.

Source files
------------

// File: rtl/dice_game_ctrl_if.sv
// Bus between the dice round sequencer and its surroundings.
//   start1/start2 : debounced single-cycle start pulses
//   dice1/dice2   : live 0..9 values from the two random generators
//   roll1/roll2   : single-cycle roll strobes to the generators
//   hold1/hold2   : latched final dice per player
//   score1/score2 : match scores
//   winner        : round result (00 none, 01 P1, 10 P2, 11 draw)
//   game_over     : high while the match is finished
//   state         : FSM state encoding for the display
// master = environment (buttons, generators, display), slave = controller.
interface dice_game_ctrl_if;
  logic       start1;
  logic       start2;
  logic [3:0] dice1;
  logic [3:0] dice2;
  logic       roll1;
  logic       roll2;
  logic [3:0] hold1;
  logic [3:0] hold2;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic       game_over;
  logic [2:0] state;

  modport master (
    output start1, start2, dice1, dice2,
    input  roll1, roll2, hold1, hold2, score1, score2, winner, game_over, state
  );

  modport slave (
    input  start1, start2, dice1, dice2,
    output roll1, roll2, hold1, hold2, score1, score2, winner, game_over, state
  );
endinterface

// File: rtl/dice_game_ctrl.sv
// Two-player dice round sequencer.
// Paces each player's generator through a burst of ROLL_TICKS roll strobes
// spaced TICK_DIV cycles apart, latches the final dice values, scores the
// round, holds the result for RESULT_HOLD cycles and ends the match when a
// player reaches WIN_SCORE.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : dice_game_ctrl_if.slave (starts/dice in, strobes/results out)
// All outputs come straight from registers.
module dice_game_ctrl #(
  parameter int TICK_DIV    = 100,
  parameter int ROLL_TICKS  = 10,
  parameter int RESULT_HOLD = 1000,
  parameter int WIN_SCORE   = 5
) (
  input  logic            clk,
  input  logic            rst,
  dice_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ROLL1  = 3'd1,
    LATCH1 = 3'd2,
    WAIT2  = 3'd3,
    ROLL2  = 3'd4,
    LATCH2 = 3'd5,
    RESULT = 3'd6,
    OVER   = 3'd7
  } state_t;

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BURST_W = $clog2(ROLL_TICKS + 1);
  localparam int HOLD_W  = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  // Strobe register is set one cycle early so it is high while tick==TICK_LAST.
  localparam logic [TICK_W-1:0]  TICK_PRE   = TICK_W'(TICK_DIV - 2);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(ROLL_TICKS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESULT_HOLD - 1);
  localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
  // With TICK_DIV==1 every cycle of a burst is a strobe cycle, including the
  // first one, so the strobe must already be set on the entering edge.
  localparam logic               STROBE_AT_WRAP = 1'(TICK_DIV == 1);

  state_t             state_reg;
  logic [TICK_W-1:0]  tick_reg;
  logic [BURST_W-1:0] burst_reg;
  logic [HOLD_W-1:0]  hold_cnt_reg;
  logic               roll1_reg;
  logic               roll2_reg;
  logic [3:0]         hold1_reg;
  logic [3:0]         hold2_reg;
  logic [3:0]         score1_reg;
  logic [3:0]         score2_reg;
  logic [1:0]         winner_reg;
  logic               game_over_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      tick_reg      <= '0;
      burst_reg     <= '0;
      hold_cnt_reg  <= '0;
      roll1_reg     <= 1'b0;
      roll2_reg     <= 1'b0;
      hold1_reg     <= 4'd0;
      hold2_reg     <= 4'd0;
      score1_reg    <= 4'd0;
      score2_reg    <= 4'd0;
      winner_reg    <= 2'b00;
      game_over_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // start1 has priority; start2 alone means nothing here.
          if (bus.start1) begin
            state_reg  <= ROLL1;
            winner_reg <= 2'b00;
            tick_reg   <= '0;
            burst_reg  <= '0;
            roll1_reg  <= STROBE_AT_WRAP;
          end
        end

        ROLL1: begin
          if (tick_reg == TICK_LAST) begin
            tick_reg <= '0;
            if (burst_reg == BURST_LAST) begin
              roll1_reg <= 1'b0;
              burst_reg <= '0;
              state_reg <= LATCH1;
            end else begin
              burst_reg <= burst_reg + 1'b1;
              roll1_reg <= STROBE_AT_WRAP;
            end
          end else begin
            tick_reg  <= tick_reg + 1'b1;
            roll1_reg <= (tick_reg == TICK_PRE);
          end
        end

        LATCH1: begin
          // Generator stepped on the edge that sampled the last strobe.
          hold1_reg <= bus.dice1;
          state_reg <= WAIT2;
        end

        WAIT2: begin
          if (bus.start2) begin
            state_reg <= ROLL2;
            tick_reg  <= '0;
            burst_reg <= '0;
            roll2_reg <= STROBE_AT_WRAP;
          end
        end

        ROLL2: begin
          if (tick_reg == TICK_LAST) begin
            tick_reg <= '0;
            if (burst_reg == BURST_LAST) begin
              roll2_reg <= 1'b0;
              burst_reg <= '0;
              state_reg <= LATCH2;
            end else begin
              burst_reg <= burst_reg + 1'b1;
              roll2_reg <= STROBE_AT_WRAP;
            end
          end else begin
            tick_reg  <= tick_reg + 1'b1;
            roll2_reg <= (tick_reg == TICK_PRE);
          end
        end

        LATCH2: begin
          // Compare against the live dice2 since hold2 updates on this same edge.
          hold2_reg    <= bus.dice2;
          hold_cnt_reg <= '0;
          state_reg    <= RESULT;
          if (hold1_reg > bus.dice2) begin
            winner_reg <= 2'b01;
            score1_reg <= score1_reg + 4'd1;
          end else if (bus.dice2 > hold1_reg) begin
            winner_reg <= 2'b10;
            score2_reg <= score2_reg + 4'd1;
          end else begin
            winner_reg <= 2'b11;
          end
        end

        RESULT: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            hold_cnt_reg <= '0;
            if ((score1_reg == WIN) || (score2_reg == WIN)) begin
              state_reg     <= OVER;
              game_over_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end

        OVER: begin
          // Only both players pressing together starts a new match.
          if (bus.start1 && bus.start2) begin
            state_reg     <= IDLE;
            game_over_reg <= 1'b0;
            hold1_reg     <= 4'd0;
            hold2_reg     <= 4'd0;
            score1_reg    <= 4'd0;
            score2_reg    <= 4'd0;
            winner_reg    <= 2'b00;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.roll1     = roll1_reg;
  assign bus.roll2     = roll2_reg;
  assign bus.hold1     = hold1_reg;
  assign bus.hold2     = hold2_reg;
  assign bus.score1    = score1_reg;
  assign bus.score2    = score2_reg;
  assign bus.winner    = winner_reg;
  assign bus.game_over = game_over_reg;
  assign bus.state     = state_reg;

endmodule
